// File: rtl/vec_strided_lsu.sv
// Strided vector load/store unit: walks vl elements at base + i*stride over a
// single-outstanding word memory port, extracting loads and lane-packing stores.
module vec_strided_lsu #(
  parameter int unsigned VL_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_store,
  input  logic [31:0]     cmd_base,
  input  logic [31:0]     cmd_stride,
  input  logic [VL_W-1:0] cmd_vl,
  input  logic [1:0]      cmd_sew,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_rdata,
  output logic            elem_we,
  output logic [VL_W-1:0] elem_idx,
  output logic [31:0]     elem_wdata,
  output logic [VL_W-1:0] elem_ridx,
  input  logic [31:0]     elem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StReq, StDone} state_e;

  state_e          state_q, state_d;
  logic            store_q, store_d;
  logic [31:0]     stride_q, stride_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [1:0]      sew_q, sew_d;
  logic [VL_W-1:0] i_q, i_d;
  logic [31:0]     a_q, a_d;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            elem_we_q, elem_we_d;
  logic [VL_W-1:0] elem_idx_q, elem_idx_d;
  logic [31:0]     elem_wdata_q, elem_wdata_d;
  logic [VL_W-1:0] elem_ridx_q, elem_ridx_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [1:0]  off;
  logic [4:0]  lane_shift;
  logic [31:0] sew_mask;
  logic [3:0]  sew_strb;
  logic        align_ok;

  assign off        = a_q[1:0];
  assign lane_shift = {off, 3'b000};

  always_comb begin
    sew_mask = 32'hffff_ffff;
    sew_strb = 4'b1111;
    align_ok = 1'b0;
    unique case (sew_q)
      2'd0: begin sew_mask = 32'h0000_00ff; sew_strb = 4'b0001; align_ok = 1'b1; end
      2'd1: begin sew_mask = 32'h0000_ffff; sew_strb = 4'b0011; align_ok = ~off[0]; end
      2'd2: align_ok = (off == 2'd0);
      2'd3: align_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    stride_d     = stride_q;
    vl_d         = vl_q;
    sew_d        = sew_q;
    i_d          = i_q;
    a_d          = a_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    elem_we_d    = 1'b0;
    elem_idx_d   = elem_idx_q;
    elem_wdata_d = elem_wdata_q;
    elem_ridx_d  = elem_ridx_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          store_d     = cmd_store;
          stride_d    = cmd_stride;
          vl_d        = cmd_vl;
          sew_d       = cmd_sew;
          i_d         = '0;
          a_d         = cmd_base;
          elem_ridx_d = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (i_q == vl_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (!align_ok) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {a_q[31:2], 2'b00};
          mem_wdata_d = store_q ? ((elem_rdata & sew_mask) << lane_shift) : 32'h0;
          mem_wstrb_d = store_q ? (sew_strb << off) : 4'b0000;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          mem_wdata_d = 32'h0;
          mem_wstrb_d = 4'b0000;
          if (!store_q) begin
            elem_we_d    = 1'b1;
            elem_idx_d   = i_q;
            elem_wdata_d = (mem_rdata >> lane_shift) & sew_mask;
          end
          i_d         = i_q + 1'b1;
          a_d         = a_q + stride_q;
          elem_ridx_d = i_q + 1'b1;
          state_d     = StIssue;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      store_q      <= 1'b0;
      stride_q     <= '0;
      vl_q         <= '0;
      sew_q        <= '0;
      i_q          <= '0;
      a_q          <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      elem_we_q    <= 1'b0;
      elem_idx_q   <= '0;
      elem_wdata_q <= '0;
      elem_ridx_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      stride_q     <= stride_d;
      vl_q         <= vl_d;
      sew_q        <= sew_d;
      i_q          <= i_d;
      a_q          <= a_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      elem_we_q    <= elem_we_d;
      elem_idx_q   <= elem_idx_d;
      elem_wdata_q <= elem_wdata_d;
      elem_ridx_q  <= elem_ridx_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign elem_we    = elem_we_q;
  assign elem_idx   = elem_idx_q;
  assign elem_wdata = elem_wdata_q;
  assign elem_ridx  = elem_ridx_q;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed self-checking bench for vec_strided_lsu with a one-cycle-latency memory
// model and a small vector register file model.
module tb_vec_strided_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_store = 1'b0;
  logic [31:0] cmd_base = '0;
  logic [31:0] cmd_stride = '0;
  logic [5:0]  cmd_vl = '0;
  logic [1:0]  cmd_sew = '0;
  logic        busy, done, err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        elem_we;
  logic [5:0]  elem_idx, elem_ridx;
  logic [31:0] elem_wdata, elem_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] vreg [0:63];

  int checks = 0;
  int failures = 0;

  logic [31:0] q_addr[$];
  logic [3:0]  q_strb[$];
  logic [31:0] q_wdata[$];
  logic [5:0]  q_idx[$];
  logic [31:0] q_edata[$];

  vec_strided_lsu #(.VL_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_store  (cmd_store),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_vl     (cmd_vl),
    .cmd_sew    (cmd_sew),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .elem_we    (elem_we),
    .elem_idx   (elem_idx),
    .elem_wdata (elem_wdata),
    .elem_ridx  (elem_ridx),
    .elem_rdata (elem_rdata)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after it first sees mem_valid.
  always @(posedge clk or posedge reset) begin
    if (reset) mem_ready <= 1'b0;
    else       mem_ready <= mem_valid && !mem_ready;
  end

  assign mem_rdata  = mem[mem_addr[9:2]];
  assign elem_rdata = vreg[elem_ridx];

  always @(negedge clk) begin
    if (mem_valid && mem_ready) begin
      q_addr.push_back(mem_addr);
      q_strb.push_back(mem_wstrb);
      q_wdata.push_back(mem_wdata);
    end
    if (elem_we) begin
      q_idx.push_back(elem_idx);
      q_edata.push_back(elem_wdata);
    end
  end

  // cyc is the cycle number (accept cycle = 1) in which done is high.
  task automatic run_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                         input logic [5:0] vl, input logic [1:0] sew,
                         output int cyc, output bit e, output bit tmo);
    int n;
    q_addr.delete(); q_strb.delete(); q_wdata.delete(); q_idx.delete(); q_edata.delete();
    @(negedge clk);
    cmd_store = st; cmd_base = base; cmd_stride = stride; cmd_vl = vl; cmd_sew = sew;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; tmo = 1'b1; e = 1'b0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (done) begin
        tmo = 1'b0; e = err;
        break;
      end
    end
    cyc = n + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_valid, mem_wstrb, mem_wdata, mem_addr, elem_we, elem_idx, elem_wdata, elem_ridx,
         busy, done, err} !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_load_sew8();
    int cyc; bit e, tmo;
    logic [31:0] exp_d [4] = '{32'h01, 32'h02, 32'h01, 32'h02};
    run_cmd(1'b0, 32'd400, 32'd1, 6'd4, 2'd0, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 14) begin
      failures++; $display("FAIL l8_done_cycle: got %0d (timeout %b) required 14", cyc, tmo);
    end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL l8_err: got %b required 0", e); end
    checks++;
    if (q_addr.size() != 4 || q_idx.size() != 4) begin
      failures++;
      $display("FAIL l8_counts: got req=%0d we=%0d required 4/4", q_addr.size(), q_idx.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q_addr[k] !== 32'd400 || q_strb[k] !== 4'b0000) begin
          failures++;
          $display("FAIL l8_req%0d: got addr=%0d strb=%b required 400/0000", k, q_addr[k],
                   q_strb[k]);
        end
        checks++;
        if (q_idx[k] !== 6'(k) || q_edata[k] !== exp_d[k]) begin
          failures++;
          $display("FAIL l8_elem%0d: got idx=%0d data=%h required %0d/%h", k, q_idx[k],
                   q_edata[k], k, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_load_sew32_neg_stride();
    int cyc; bit e, tmo;
    logic [31:0] exp_a [3] = '{32'd408, 32'd404, 32'd400};
    logic [31:0] exp_d [3] = '{32'h02010201, 32'h01030100, 32'h02010201};
    run_cmd(1'b0, 32'd408, -32'sd4, 6'd3, 2'd2, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 11 || e !== 1'b0) begin
      failures++; $display("FAIL l32_done: got cyc=%0d err=%b required 11/0", cyc, e);
    end
    checks++;
    if (q_addr.size() != 3 || q_idx.size() != 3) begin
      failures++;
      $display("FAIL l32_counts: got req=%0d we=%0d required 3/3", q_addr.size(), q_idx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q_addr[k] !== exp_a[k] || q_edata[k] !== exp_d[k]) begin
          failures++;
          $display("FAIL l32_step%0d: got addr=%0d data=%h required %0d/%h", k, q_addr[k],
                   q_edata[k], exp_a[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_load_sew16_offset();
    int cyc; bit e, tmo;
    run_cmd(1'b0, 32'd406, 32'd0, 6'd1, 2'd1, cyc, e, tmo);
    checks++;
    if (tmo || e !== 1'b0 || q_addr.size() != 1 || q_edata.size() != 1) begin
      failures++; $display("FAIL l16_shape: got req=%0d err=%b required 1/0", q_addr.size(), e);
    end else begin
      checks++;
      if (q_addr[0] !== 32'd404 || q_edata[0] !== 32'h0000_0103) begin
        failures++;
        $display("FAIL l16_data: got addr=%0d data=%h required 404/00000103", q_addr[0],
                 q_edata[0]);
      end
    end
  endtask

  task automatic test_store();
    int cyc; bit e, tmo;
    vreg[0] = 32'h1234_56aa;
    vreg[1] = 32'hffff_ffbb;
    run_cmd(1'b1, 32'd801, 32'd4, 6'd2, 2'd0, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 8 || e !== 1'b0 || q_idx.size() != 0) begin
      failures++;
      $display("FAIL s8_done: got cyc=%0d err=%b we=%0d required 8/0/0", cyc, e, q_idx.size());
    end
    checks++;
    if (q_addr.size() != 2) begin
      failures++; $display("FAIL s8_count: got %0d required 2", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 32'd800 || q_strb[0] !== 4'b0010 || q_wdata[0] !== 32'h0000_aa00) begin
        failures++;
        $display("FAIL s8_req0: got %0d/%b/%h required 800/0010/0000aa00", q_addr[0],
                 q_strb[0], q_wdata[0]);
      end
      checks++;
      if (q_addr[1] !== 32'd804 || q_strb[1] !== 4'b0010 || q_wdata[1] !== 32'h0000_bb00) begin
        failures++;
        $display("FAIL s8_req1: got %0d/%b/%h required 804/0010/0000bb00", q_addr[1],
                 q_strb[1], q_wdata[1]);
      end
    end
    vreg[0] = 32'hdead_beef;
    run_cmd(1'b1, 32'd402, 32'd4, 6'd1, 2'd1, cyc, e, tmo);
    checks++;
    if (tmo || q_addr.size() != 1) begin
      failures++; $display("FAIL s16_count: got %0d required 1", q_addr.size());
    end else if (q_addr[0] !== 32'd400 || q_strb[0] !== 4'b1100 ||
                 q_wdata[0] !== 32'hbeef_0000) begin
      failures++;
      $display("FAIL s16_req: got %0d/%b/%h required 400/1100/beef0000", q_addr[0], q_strb[0],
               q_wdata[0]);
    end
  endtask

  task automatic test_misalign();
    int cyc; bit e, tmo;
    run_cmd(1'b0, 32'd400, 32'd3, 6'd4, 2'd1, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 5 || e !== 1'b1) begin
      failures++; $display("FAIL mis_done: got cyc=%0d err=%b required 5/1", cyc, e);
    end
    checks++;
    if (q_addr.size() != 1 || q_idx.size() != 1) begin
      failures++;
      $display("FAIL mis_counts: got req=%0d we=%0d required 1/1", q_addr.size(), q_idx.size());
    end else if (q_idx[0] !== 6'd0 || q_edata[0] !== 32'h0000_0201) begin
      failures++;
      $display("FAIL mis_elem: got %0d/%h required 0/00000201", q_idx[0], q_edata[0]);
    end
  endtask

  task automatic test_degenerate();
    int cyc; bit e, tmo;
    run_cmd(1'b0, 32'd400, 32'd4, 6'd0, 2'd2, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 2 || e !== 1'b0 || q_addr.size() != 0) begin
      failures++;
      $display("FAIL vl0: got cyc=%0d err=%b req=%0d required 2/0/0", cyc, e, q_addr.size());
    end
    run_cmd(1'b1, 32'd400, 32'd4, 6'd2, 2'd3, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 2 || e !== 1'b1 || q_addr.size() != 0) begin
      failures++;
      $display("FAIL sew3: got cyc=%0d err=%b req=%0d required 2/1/0", cyc, e, q_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n; bit e, tmo, seen;
    q_idx.delete(); q_edata.delete();
    @(negedge clk);
    cmd_store = 1'b0; cmd_base = 32'd400; cmd_stride = 32'd1; cmd_vl = 6'd8; cmd_sew = 2'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_valid && elem_ridx == 6'd2) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || busy !== 1'b1 || mem_addr !== 32'd400) begin
      failures++;
      $display("FAIL rst_mid_setup: got seen=%b busy=%b addr=%0d required 1/1/400", seen, busy,
               mem_addr);
    end
    #2 reset = 1'b1;
    #1;
    test_reset();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL rst_mid_done: got done=1 required 0"); end
    reset = 1'b0;
    run_cmd(1'b0, 32'd400, 32'd1, 6'd2, 2'd0, cyc, e, tmo);
    checks++;
    if (tmo || cyc != 8 || e !== 1'b0 || q_idx.size() != 2) begin
      failures++;
      $display("FAIL rst_after: got cyc=%0d err=%b we=%0d required 8/0/2", cyc, e, q_idx.size());
    end else if (q_idx[0] !== 6'd0 || q_edata[0] !== 32'h01 || q_idx[1] !== 6'd1 ||
                 q_edata[1] !== 32'h02) begin
      failures++;
      $display("FAIL rst_after_elems: got %0d/%h %0d/%h required 0/01 1/02", q_idx[0],
               q_edata[0], q_idx[1], q_edata[1]);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    for (int k = 0; k < 64; k++) vreg[k] = 32'h0;
    mem[100] = 32'h0201_0201;
    mem[101] = 32'h0103_0100;
    mem[102] = 32'h0201_0201;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_load_sew8();
    test_load_sew32_neg_stride();
    test_load_sew16_offset();
    test_store();
    test_misalign();
    test_degenerate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
